// File: rtl/rs_alu_pipe.sv
// rs_alu_pipe: pipelined reservation-station execute unit.
//
// Takes one issued op per cycle from the RS, computes the ALU, branch or
// jump result in front of stage 0, and carries it through LATENCY register
// stages. valid/ready backpressure runs toward the CDB arbiter. Supports a
// whole-pipeline flush on ROB rollback and a global rdy freeze.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> MUL/MULH/MULHSU/MULHU supported. The product is split over
//                stages 0 and 1, so LATENCY must be at least 2.
//   undefined -> those opcodes are unknown. They give data=0, jump_sign=0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global enable; 0 freezes all state
//   rollback           flush every stage; input not accepted
//   in_valid/in_ready  issue handshake from the RS
//   in_opnum, in_v1, in_v2, in_imm, in_pc, in_rob_id   issued op
//   out_valid/out_ready  result handshake toward the CDB
//   out_data, out_jump_sign, out_jump_pc, out_rob_id   result of last stage

`ifndef OPNUM_NULL
`define OPNUM_NULL   0
`define OPNUM_LUI    1
`define OPNUM_AUIPC  2
`define OPNUM_JAL    3
`define OPNUM_JALR   4
`define OPNUM_BEQ    5
`define OPNUM_BNE    6
`define OPNUM_BLT    7
`define OPNUM_BGE    8
`define OPNUM_BLTU   9
`define OPNUM_BGEU   10
`define OPNUM_ADDI   19
`define OPNUM_SLTI   20
`define OPNUM_SLTIU  21
`define OPNUM_XORI   22
`define OPNUM_ORI    23
`define OPNUM_ANDI   24
`define OPNUM_SLLI   25
`define OPNUM_SRLI   26
`define OPNUM_SRAI   27
`define OPNUM_ADD    28
`define OPNUM_SUB    29
`define OPNUM_SLL    30
`define OPNUM_SLT    31
`define OPNUM_SLTU   32
`define OPNUM_XOR    33
`define OPNUM_SRL    34
`define OPNUM_SRA    35
`define OPNUM_OR     36
`define OPNUM_AND    37
`define OPNUM_MUL    38
`define OPNUM_MULH   39
`define OPNUM_MULHSU 40
`define OPNUM_MULHU  41
`endif

module rs_alu_pipe #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4,
  parameter int OP_W     = 6,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_opnum,
  input  logic [XLEN-1:0]     in_v1,
  input  logic [XLEN-1:0]     in_v2,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic                out_jump_sign,
  output logic [XLEN-1:0]     out_jump_pc,
  output logic [ROB_ID_W-1:0] out_rob_id
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_NULL  = OP_W'(`OPNUM_NULL);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(`OPNUM_LUI);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(`OPNUM_AUIPC);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(`OPNUM_JAL);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(`OPNUM_JALR);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(`OPNUM_BEQ);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(`OPNUM_BNE);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(`OPNUM_BLT);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(`OPNUM_BGE);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(`OPNUM_BLTU);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(`OPNUM_BGEU);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(`OPNUM_ADDI);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(`OPNUM_SLTI);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(`OPNUM_SLTIU);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(`OPNUM_XORI);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(`OPNUM_ORI);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(`OPNUM_ANDI);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(`OPNUM_SLLI);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(`OPNUM_SRLI);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(`OPNUM_SRAI);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(`OPNUM_ADD);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(`OPNUM_SUB);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(`OPNUM_SLL);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(`OPNUM_SLT);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(`OPNUM_SLTU);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(`OPNUM_XOR);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(`OPNUM_SRL);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(`OPNUM_SRA);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(`OPNUM_OR);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(`OPNUM_AND);

  if (LATENCY < 1 || LATENCY > 4) begin : g_lat_chk
    $error("rs_alu_pipe: LATENCY must be in 1..4");
  end

  // ---------------------------------------------------------------------
  // Front-end compute (combinational, feeds stage 0)
  // ---------------------------------------------------------------------
  logic [SHW-1:0]  w_shamt_r;
  logic [SHW-1:0]  w_shamt_i;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_jalr_sum;
  logic            w_is_br;
  logic            w_taken;
  logic [XLEN-1:0] w_data;
  logic            w_js;
  logic [XLEN-1:0] w_jpc;

  // Shift amounts use only the low log2(XLEN) bits; upper bits are ignored.
  assign w_shamt_r  = in_v2[SHW-1:0];
  assign w_shamt_i  = in_imm[SHW-1:0];
  assign w_pc_imm   = in_pc + in_imm;
  assign w_pc4      = in_pc + XLEN'(4);
  assign w_jalr_sum = in_v1 + in_imm;

  always_comb begin : c_branch
    w_is_br = 1'b1;
    w_taken = 1'b0;
    case (in_opnum)
      OP_BEQ:  w_taken = (in_v1 == in_v2);
      OP_BNE:  w_taken = (in_v1 != in_v2);
      OP_BLT:  w_taken = ($signed(in_v1) <  $signed(in_v2));
      OP_BGE:  w_taken = ($signed(in_v1) >= $signed(in_v2));
      OP_BLTU: w_taken = (in_v1 <  in_v2);
      OP_BGEU: w_taken = (in_v1 >= in_v2);
      default: w_is_br = 1'b0;
    endcase
  end

  always_comb begin : c_alu
    w_data = '0;
    w_js   = 1'b0;
    w_jpc  = '0;
    case (in_opnum)
      OP_LUI:   w_data = in_imm;
      OP_AUIPC: w_data = w_pc_imm;
      OP_JAL: begin
        w_data = w_pc4;
        w_js   = 1'b1;
        w_jpc  = w_pc_imm;
      end
      OP_JALR: begin
        w_data = w_pc4;
        w_js   = 1'b1;
        w_jpc  = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_ADDI:  w_data = in_v1 + in_imm;
      OP_SLTI:  w_data = XLEN'($signed(in_v1) < $signed(in_imm));
      OP_SLTIU: w_data = XLEN'(in_v1 < in_imm);
      OP_XORI:  w_data = in_v1 ^ in_imm;
      OP_ORI:   w_data = in_v1 | in_imm;
      OP_ANDI:  w_data = in_v1 & in_imm;
      OP_SLLI:  w_data = in_v1 << w_shamt_i;
      OP_SRLI:  w_data = in_v1 >> w_shamt_i;
      OP_SRAI:  w_data = $signed(in_v1) >>> w_shamt_i;
      OP_ADD:   w_data = in_v1 + in_v2;
      OP_SUB:   w_data = in_v1 - in_v2;
      OP_SLL:   w_data = in_v1 << w_shamt_r;
      OP_SLT:   w_data = XLEN'($signed(in_v1) < $signed(in_v2));
      OP_SLTU:  w_data = XLEN'(in_v1 < in_v2);
      OP_XOR:   w_data = in_v1 ^ in_v2;
      OP_SRL:   w_data = in_v1 >> w_shamt_r;
      OP_SRA:   w_data = $signed(in_v1) >>> w_shamt_r;
      OP_OR:    w_data = in_v1 | in_v2;
      OP_AND:   w_data = in_v1 & in_v2;
      default:  ;
    endcase
    // Branch target is reported whether or not the branch is taken.
    if (w_is_br) begin
      w_data = XLEN'(w_taken);
      w_js   = w_taken;
      w_jpc  = w_pc_imm;
    end
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------
  // Multiply: operand B is split into a low half (unsigned) and a high part
  // (signed, carries B's sign extension). Both partial products are
  // registered alongside stage 0 and summed on the way into stage 1.
  // ---------------------------------------------------------------------
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(`OPNUM_MUL);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(`OPNUM_MULH);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(`OPNUM_MULHSU);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(`OPNUM_MULHU);
  localparam int HALF = XLEN / 2;
  localparam int PPW  = XLEN + HALF + 2;
  localparam int PW   = 2 * XLEN;

  if (LATENCY < 2) begin : g_mul_lat_chk
    $error("rs_alu_pipe: ALU_MUL_EN needs LATENCY >= 2");
  end

  logic                  w_is_mul;
  logic [1:0]            w_mul_sel;
  logic                  w_a_sgn;
  logic                  w_b_sgn;
  logic [XLEN:0]         w_a_ext;
  logic [XLEN:0]         w_b_ext;
  logic signed [PPW-1:0] w_pp_lo;
  logic signed [PPW-1:0] w_pp_hi;
  logic signed [PW-1:0]  w_prod;
  logic [XLEN-1:0]       w_mul_res;

  logic                  r_mul_v;
  logic [1:0]            r_mul_sel;
  logic signed [PPW-1:0] r_pp_lo;
  logic signed [PPW-1:0] r_pp_hi;

  // sel: 0 low half, 1 MULH, 2 MULHSU, 3 MULHU
  always_comb begin : c_mul_dec
    w_is_mul  = 1'b1;
    w_mul_sel = 2'd0;
    w_a_sgn   = 1'b0;
    w_b_sgn   = 1'b0;
    case (in_opnum)
      OP_MUL:    w_mul_sel = 2'd0;
      OP_MULH: begin
        w_mul_sel = 2'd1;
        w_a_sgn   = 1'b1;
        w_b_sgn   = 1'b1;
      end
      OP_MULHSU: begin
        w_mul_sel = 2'd2;
        w_a_sgn   = 1'b1;
      end
      OP_MULHU:  w_mul_sel = 2'd3;
      default:   w_is_mul = 1'b0;
    endcase
  end

  assign w_a_ext = {w_a_sgn & in_v1[XLEN-1], in_v1};
  assign w_b_ext = {w_b_sgn & in_v2[XLEN-1], in_v2};
  assign w_pp_lo = PPW'($signed(w_a_ext)) * PPW'($signed({1'b0, in_v2[HALF-1:0]}));
  assign w_pp_hi = PPW'($signed(w_a_ext)) * PPW'($signed(w_b_ext[XLEN:HALF]));

  assign w_prod    = PW'(r_pp_lo) + (PW'(r_pp_hi) <<< HALF);
  assign w_mul_res = (r_mul_sel == 2'd0) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
`endif

  // ---------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------
  logic                r_vld  [LATENCY];
  logic [XLEN-1:0]     r_data [LATENCY];
  logic                r_js   [LATENCY];
  logic [XLEN-1:0]     r_jpc  [LATENCY];
  logic [ROB_ID_W-1:0] r_rob  [LATENCY];

  logic [XLEN-1:0]     w_nx_data [LATENCY];
  logic                w_nx_js   [LATENCY];
  logic [XLEN-1:0]     w_nx_jpc  [LATENCY];
  logic [ROB_ID_W-1:0] w_nx_rob  [LATENCY];

  logic [LATENCY-1:0]  w_adv;
  logic [LATENCY-1:0]  w_ld;
  logic                w_acc;
  logic                w_load0;

  // Stage k advances if it is valid and there is a hole anywhere downstream
  // or the last stage is being taken by the CDB. Walking from the output
  // end keeps this a plain chain without self-feedback.
  always_comb begin : c_adv
    logic v_go;
    v_go  = out_ready;
    w_adv = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      w_adv[k] = r_vld[k] & v_go;
      v_go     = v_go | ~r_vld[k];
    end
  end

  assign in_ready = ~r_vld[0] | w_adv[0];
  assign w_acc    = in_valid & in_ready & rdy & ~rollback;
  // NULL ops are consumed but never occupy a stage.
  assign w_load0  = w_acc & (in_opnum != OP_NULL);

  always_comb begin : c_ld
    w_ld    = '0;
    w_ld[0] = w_load0;
    for (int k = 1; k < LATENCY; k++) begin
      w_ld[k] = w_adv[k-1];
    end
  end

  always_comb begin : c_next
    w_nx_data[0] = w_data;
    w_nx_js[0]   = w_js;
    w_nx_jpc[0]  = w_jpc;
    w_nx_rob[0]  = in_rob_id;
    for (int k = 1; k < LATENCY; k++) begin
      w_nx_data[k] = r_data[k-1];
      w_nx_js[k]   = r_js[k-1];
      w_nx_jpc[k]  = r_jpc[k-1];
      w_nx_rob[k]  = r_rob[k-1];
    end
`ifdef ALU_MUL_EN
    if (r_mul_v) w_nx_data[1] = w_mul_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_js[k]   <= 1'b0;
        r_jpc[k]  <= '0;
        r_rob[k]  <= '0;
      end
`ifdef ALU_MUL_EN
      r_mul_v   <= 1'b0;
      r_mul_sel <= 2'd0;
      r_pp_lo   <= '0;
      r_pp_hi   <= '0;
`endif
    end else if (rdy) begin
      if (rollback) begin
        for (int k = 0; k < LATENCY; k++) begin
          r_vld[k] <= 1'b0;
        end
`ifdef ALU_MUL_EN
        r_mul_v <= 1'b0;
`endif
      end else begin
        for (int k = 0; k < LATENCY; k++) begin
          if (w_ld[k]) begin
            r_vld[k]  <= 1'b1;
            r_data[k] <= w_nx_data[k];
            r_js[k]   <= w_nx_js[k];
            r_jpc[k]  <= w_nx_jpc[k];
            r_rob[k]  <= w_nx_rob[k];
          end else if (w_adv[k]) begin
            r_vld[k] <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        if (w_load0) begin
          r_mul_v   <= w_is_mul;
          r_mul_sel <= w_mul_sel;
          r_pp_lo   <= w_pp_lo;
          r_pp_hi   <= w_pp_hi;
        end
`endif
      end
    end
  end

  assign out_valid     = r_vld[LATENCY-1];
  assign out_data      = r_data[LATENCY-1];
  assign out_jump_sign = r_js[LATENCY-1];
  assign out_jump_pc   = r_jpc[LATENCY-1];
  assign out_rob_id    = r_rob[LATENCY-1];

endmodule

// File: doc/rs_alu_pipe.md
Name: rs_alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle reservation-station execute unit.
- Accepts one issued op per cycle from the RS and computes ALU, branch and jump results at XLEN width.
- Carries results through a configurable-depth pipeline with valid/ready backpressure toward the CDB arbiter.
- Supports whole-pipeline flush on ROB rollback and the global rdy pause.

Parameters:
XLEN, 32, datapath and address width
ROB_ID_W, 4, ROB tag width
OP_W, 6, opnum width (`OPNUM_* encodings from defines.v)
LATENCY, 2, pipeline stages from accept to result valid; legal 1..4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 freezes all state
rollback  in  1  ROB misprediction flush
in_valid  in  1  RS issues an op this cycle
in_ready  out  1  unit can accept this cycle
in_opnum  in  OP_W  operation code
in_v1  in  XLEN  operand 1
in_v2  in  XLEN  operand 2
in_imm  in  XLEN  sign-extended immediate
in_pc  in  XLEN  instruction pc
in_rob_id  in  ROB_ID_W  destination ROB tag
out_valid  out  1  result present at final stage
out_ready  in  1  CDB accepts result
out_data  out  XLEN  result value (branch: 0/1 taken)
out_jump_sign  out  1  jump/branch taken
out_jump_pc  out  XLEN  target pc
out_rob_id  out  ROB_ID_W  tag of result

Behaviour:
- Reset (rst=1 at posedge, regardless of rdy): all stage valids 0; out_valid=0; out_data, out_jump_pc, out_rob_id = 0; out_jump_sign=0.
- Accept: transfer occurs when in_valid & in_ready & rdy & !rollback. An op with in_opnum == `OPNUM_NULL is dropped and never creates a valid stage.
- Compute: combinational in front of stage 0, same semantics as the existing execute unit for LUI, AUIPC, JAL, JALR, the branches, R-type and I-type ops.
  - Shift amount uses only v2/imm[$clog2(XLEN)-1:0]; upper bits are ignored.
  - SRA/SRAI are arithmetic (signed).
  - JALR target has bit 0 cleared.
  - Branch out_data = {XLEN-1 zeros, taken}.
  - All arithmetic wraps modulo 2^XLEN.
- Pipeline: LATENCY register stages, each holding {valid, data, jump_sign, jump_pc, rob_id}. Outputs are driven directly from the last stage, so latency is exactly LATENCY cycles from accept to out_valid when there is no stall.
- Advance rule: stage k advances when stage k+1 is empty or advancing. The last stage advances when out_valid & out_ready. Bubbles collapse.
- in_ready = !stage0.valid | stage0 advancing (full throughput under continuous out_ready).
- Stall: when out_ready=0 with out_valid=1, the last stage holds and all outputs stay stable until accepted. Upstream stages fill; in_ready drops only when every stage is full.
- rollback=1 with rdy=1: at the posedge all valids clear and the input is not accepted. out_valid=0 the next cycle. A result with out_valid & out_ready in the same cycle as rollback counts as not delivered.
- rdy=0: no state change, no accept; the CDB must not sample.
- Priority: rst > rdy=0 hold > rollback > normal advance.

Optional Feature:
ALU_MUL_EN:
- Defined: adds `OPNUM_MUL, `OPNUM_MULH, `OPNUM_MULHSU and `OPNUM_MULHU (RV32M semantics at XLEN, low/high halves of the 2*XLEN product).
  - Multiply is computed across stages 0 and 1; partial products are registered in stage 0.
  - The implementation must enforce LATENCY>=2 with an elaboration-time error.
- Undefined: these opcodes are treated as unknown and produce a valid result with data=0 and jump_sign=0.

Test Plan:
- Reset then ADDI v1=5 imm=-3 rob=3, LATENCY=2, out_ready=1 -> out_valid exactly 2 cycles after accept, data=2, rob_id=3, jump_sign=0.
- Back-to-back ADD (7+8), SUB (3-5), SRA (0x80000000 >> v2=0x21) -> results 15, 0xFFFFFFFE, 0xC0000000 on consecutive cycles (shift amount masked to 1).
- BLT v1=-1 v2=1 pc=0x100 imm=0x20 -> data=1, jump_sign=1, jump_pc=0x120. JALR v1=0x203 imm=0 pc=0x40 -> jump_pc=0x202, data=0x44.
- Hold out_ready=0 while issuing 3 ops -> outputs stable on op 1, in_ready falls after LATENCY ops accepted. Release -> ops 1..3 delivered in order, no loss or duplicate.
- Two ops in flight then rollback=1 for one cycle -> out_valid=0 next cycle and stays 0. An op issued the cycle after rollback completes normally.
- ALU_MUL_EN defined: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0. MULHU of same -> 0xFFFFFFFE. Undefined: MUL -> data=0 with out_valid=1.
